// File: rtl/tx_cmd_pacer.sv
// Command byte pacer: small FIFO in front of the UART transmitter that launches one byte at a time
// and enforces an idle gap after each transmission completes before the next launch.
module tx_cmd_pacer #(
  parameter int DEPTH      = 4,
  parameter int GAP_CYCLES = 50000,
  parameter int BUSY_WAIT  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               cmd_in,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  output logic [7:0]               uart_data,
  output logic                     uart_start,
  input  logic                     uart_busy,
  output logic [7:0]               prev_tx,
  output logic                     sent_pulse,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     idle
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int TMR_MAX = (GAP_CYCLES > BUSY_WAIT) ? GAP_CYCLES : BUSY_WAIT;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [TMR_W-1:0] GAP_LAST = TMR_W'(GAP_CYCLES - 1);
  localparam logic [TMR_W-1:0] BSY_LAST = TMR_W'(BUSY_WAIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT_BSY,
    S_WAIT_DONE,
    S_GAP
  } state_t;

  state_t            state;
  logic [7:0]        mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [TMR_W-1:0]  tmr;
  logic              push;
  logic              pop;

  // Ready comes from the registered count, so a full FIFO refuses a push even in the pop cycle.
  assign cmd_ready = (fifo_count < CNT_W'(DEPTH));
  assign push      = cmd_valid && cmd_ready;
  assign pop       = (state == S_LAUNCH);
  assign idle      = (fifo_count == '0) && (state == S_IDLE);

  // NOTE: the storage array has no reset; pointers and count alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= cmd_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      tmr        <= '0;
      uart_start <= 1'b0;
      sent_pulse <= 1'b0;
      uart_data  <= 8'h00;
      prev_tx    <= 8'h00;
    end else begin
      // NOTE: pulses default low here; a later non-blocking assignment in the same edge wins.
      uart_start <= 1'b0;
      sent_pulse <= 1'b0;
      case (state)
        S_IDLE: begin
          if (fifo_count != '0) state <= S_LAUNCH;
        end
        S_LAUNCH: begin
          uart_data  <= mem[rd_ptr];
          prev_tx    <= mem[rd_ptr];
          uart_start <= 1'b1;
          tmr        <= '0;
          state      <= S_WAIT_BSY;
        end
        S_WAIT_BSY: begin
          // A UART that never raises busy is treated as having sent the byte after BUSY_WAIT clocks.
          if (uart_busy) begin
            state <= S_WAIT_DONE;
          end else if (tmr == BSY_LAST) begin
            sent_pulse <= 1'b1;
            tmr        <= '0;
            state      <= S_GAP;
          end else begin
            tmr <= tmr + TMR_W'(1);
          end
        end
        S_WAIT_DONE: begin
          if (!uart_busy) begin
            sent_pulse <= 1'b1;
            tmr        <= '0;
            state      <= S_GAP;
          end
        end
        S_GAP: begin
          if (tmr == GAP_LAST) state <= S_IDLE;
          else                 tmr   <= tmr + TMR_W'(1);
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tx_cmd_pacer.sv
// Self-checking bench for tx_cmd_pacer: directed scenarios plus random traffic, checked every cycle
// against a launch-schedule model derived from the pacing rules (push time, completion time, gap).
module tb_tx_cmd_pacer;

  localparam int DEPTH = 4;
  localparam int GAP   = 5;
  localparam int BW    = 8;

  logic                    clk       = 1'b0;
  logic                    rst       = 1'b1;
  logic [7:0]              cmd_in    = 8'h00;
  logic                    cmd_valid = 1'b0;
  logic                    uart_busy = 1'b0;
  logic                    cmd_ready;
  logic                    uart_start;
  logic                    sent_pulse;
  logic                    idle;
  logic [7:0]              uart_data;
  logic [7:0]              prev_tx;
  logic [$clog2(DEPTH):0]  fifo_count;

  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  tx_cmd_pacer #(.DEPTH(DEPTH), .GAP_CYCLES(GAP), .BUSY_WAIT(BW)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_in     (cmd_in),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .uart_data  (uart_data),
    .uart_start (uart_start),
    .uart_busy  (uart_busy),
    .prev_tx    (prev_tx),
    .sent_pulse (sent_pulse),
    .fifo_count (fifo_count),
    .idle       (idle)
  );

  // Reference model: each accepted byte gets a predicted launch edge and completion edge.
  int         pend_launch[$];
  logic [7:0] pend_byte[$];
  int         sent_at[$];
  int         release_at = 0;
  logic [7:0] exp_last   = 8'h00;

  int busy_mode = 0;
  int bdly      = 0;
  int blen      = 1;

  int         obs_cyc[$];
  logic [7:0] obs_byte[$];

  int passed = 0;
  int total  = 0;

  // UART stand-in: raises busy bdly cycles after seeing start, holds it blen cycles.
  always @(negedge clk) begin
    if (uart_start && busy_mode == 1) begin
      repeat (bdly) @(negedge clk);
      uart_busy = 1'b1;
      repeat (blen) @(negedge clk);
      uart_busy = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s at cycle %0d: observed %0h, expected %0h", tag, cyc, obs, exp);
  endtask

  task automatic cycle_checks();
    logic exp_start;
    logic exp_sent;
    exp_start = 1'b0;
    exp_sent  = 1'b0;
    if (pend_launch.size() > 0) begin
      if (pend_launch[0] == cyc) begin
        exp_start = 1'b1;
        exp_last  = pend_byte.pop_front();
        void'(pend_launch.pop_front());
      end
    end
    if (sent_at.size() > 0) begin
      if (sent_at[0] == cyc) begin
        exp_sent = 1'b1;
        void'(sent_at.pop_front());
      end
    end
    check("uart_start", 32'(uart_start), 32'(exp_start));
    check("sent_pulse", 32'(sent_pulse), 32'(exp_sent));
    check("fifo_count", 32'(fifo_count), 32'(pend_launch.size()));
    check("cmd_ready",  32'(cmd_ready),  32'(pend_launch.size() < DEPTH));
    check("idle",       32'(idle),       32'((pend_launch.size() == 0) && (cyc >= release_at)));
    check("uart_data",  32'(uart_data),  32'(exp_last));
    check("prev_tx",    32'(prev_tx),    32'(exp_last));
    if (uart_start) begin
      obs_cyc.push_back(cyc);
      obs_byte.push_back(uart_data);
    end
  endtask

  // One clock: drive inputs for the next edge, update the model, then check after that edge.
  task automatic step(input logic r, input logic v, input logic [7:0] d, output logic acc);
    int p;
    int l;
    int e;
    rst       = r;
    cmd_valid = v;
    cmd_in    = d;
    acc       = !r && v && (pend_launch.size() < DEPTH);
    if (acc) begin
      p = cyc + 1;
      l = ((p > release_at) ? p : release_at) + 2;
      e = l + ((busy_mode == 1) ? (bdly + blen + 1) : BW);
      pend_launch.push_back(l);
      pend_byte.push_back(d);
      sent_at.push_back(e);
      release_at = e + GAP;
    end
    @(negedge clk);
    if (r) begin
      pend_launch.delete();
      pend_byte.delete();
      sent_at.delete();
      exp_last   = 8'h00;
      release_at = cyc;
    end
    cycle_checks();
  endtask

  task automatic idle_cycles(input int n);
    logic acc;
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00, acc);
  endtask

  task automatic reset_cycles(input int n);
    logic acc;
    for (int i = 0; i < n; i++) step(1'b1, 1'b1, 8'hEE, acc);
  endtask

  task automatic push_byte(input logic [7:0] d);
    logic acc;
    int   n;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 200) begin
      step(1'b0, 1'b1, d, acc);
      n++;
    end
    if (!acc) begin
      total++;
      $error("FAIL push_timeout byte %0h: not accepted after %0d cycles, required acceptance", d, n);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (n < 3000 && (pend_launch.size() != 0 || cyc <= release_at)) begin
      idle_cycles(1);
      n++;
    end
  endtask

  task automatic check_order(input string tag, input logic [7:0] exp_bytes[$]);
    check({tag, "_count"}, 32'(obs_byte.size()), 32'(exp_bytes.size()));
    for (int i = 0; i < exp_bytes.size() && i < obs_byte.size(); i++)
      check({tag, "_byte"}, 32'(obs_byte[i]), 32'(exp_bytes[i]));
  endtask

  task automatic check_spacing(input string tag, input int exp_gap);
    for (int i = 1; i < obs_cyc.size(); i++)
      check(tag, 32'(obs_cyc[i] - obs_cyc[i-1]), 32'(exp_gap));
  endtask

  initial begin
    logic [7:0] exp_bytes[$];
    logic       acc;
    logic       holding;
    logic [7:0] hd;
    int         push_edge;

    reset_cycles(3);
    idle_cycles(3);

    // Single byte, busy one cycle after start for 10 clocks.
    busy_mode = 1; bdly = 1; blen = 10;
    obs_cyc.delete(); obs_byte.delete();
    push_edge = cyc + 1;
    push_byte(8'hA7);
    drain();
    check("t2_starts", 32'(obs_cyc.size()), 32'd1);
    check("t2_latency", 32'((obs_cyc.size() > 0) ? obs_cyc[0] - push_edge : -1), 32'd2);
    exp_bytes = '{8'hA7};
    check_order("t2", exp_bytes);
    check("t2_idle", 32'(idle), 32'd1);

    // Fill with busy held low: timeout path, FIFO full refusals, push in the pop cycle.
    busy_mode = 0;
    obs_cyc.delete(); obs_byte.delete();
    push_byte(8'h10);
    push_byte(8'h11);
    push_byte(8'h22);
    push_byte(8'h33);
    push_byte(8'h44);
    push_byte(8'h55);
    push_byte(8'h66);
    drain();
    exp_bytes = '{8'h10, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    check_order("t3", exp_bytes);
    check_spacing("t3_spacing", 2 + BW + GAP);

    // Reset in the middle of a stream: everything pending is dropped.
    push_byte(8'h71);
    push_byte(8'h72);
    push_byte(8'h73);
    idle_cycles(4);
    reset_cycles(3);
    obs_cyc.delete(); obs_byte.delete();
    idle_cycles(20);
    check("t1_no_start", 32'(obs_cyc.size()), 32'd0);
    check("t1_prev_tx", 32'(prev_tx), 32'h00);

    // Slow busy: rises 3 clocks after start, stays up 40.
    busy_mode = 1; bdly = 3; blen = 40;
    obs_cyc.delete(); obs_byte.delete();
    push_byte(8'hB1);
    push_byte(8'hB2);
    drain();
    exp_bytes = '{8'hB1, 8'hB2};
    check_order("t5", exp_bytes);
    check_spacing("t5_spacing", 3 + 40 + 1 + GAP + 2);

    // Ten bytes through a four-entry FIFO.
    busy_mode = 1; bdly = 0; blen = 2;
    obs_cyc.delete(); obs_byte.delete();
    exp_bytes.delete();
    for (int i = 1; i <= 10; i++) begin
      push_byte(8'(i));
      exp_bytes.push_back(8'(i));
    end
    drain();
    check_order("t6", exp_bytes);
    check("t6_count", 32'(fifo_count), 32'd0);
    check("t6_idle", 32'(idle), 32'd1);

    // Random traffic under random UART behaviour.
    for (int b = 0; b < 4; b++) begin
      busy_mode = int'($urandom_range(0, 1));
      bdly      = int'($urandom_range(0, 6));
      blen      = int'($urandom_range(1, 12));
      holding   = 1'b0;
      hd        = 8'h00;
      for (int i = 0; i < 250; i++) begin
        if (!holding && $urandom_range(0, 2) == 0) begin
          holding = 1'b1;
          hd      = 8'($urandom);
        end
        step(1'b0, holding, hd, acc);
        if (acc) holding = 1'b0;
      end
      drain();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", passed, total);
    $fatal(1, "watchdog expired");
  end

endmodule
